// File: rtl/colour_bbox_detect.sv
// Colour-threshold bounding-box detector on an Avalon-ST video stream.
// Beats pass through one register stage; each complete video frame publishes the box of its hit pixels.
module colour_bbox_detect #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int CW    = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [23:0]   sink_data,
   input  logic          sink_valid,
   output logic          sink_ready,
   input  logic          sink_sop,
   input  logic          sink_eop,
   output logic [23:0]   source_data,
   output logic          source_valid,
   input  logic          source_ready,
   output logic          source_sop,
   output logic          source_eop,
   input  logic [7:0]    r_min,
   input  logic [7:0]    g_max,
   input  logic [7:0]    b_max,
   output logic [CW-1:0] bbox_x_min,
   output logic [CW-1:0] bbox_x_max,
   output logic [CW-1:0] bbox_y_min,
   output logic [CW-1:0] bbox_y_max,
   output logic          bbox_valid,
   output logic          bbox_strobe
);

   typedef enum logic [1:0] {ST_IDLE, ST_VIDEO, ST_OTHER} state_t;

   localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] Y_END  = CW'(IMG_H);

   state_t        state, state_nxt;
   logic          sink_xfer, pixel_xfer, in_frame, hit;
   logic [CW-1:0] x_cnt, y_cnt;
   logic          acc_valid, acc_valid_nxt;
   logic [CW-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
   logic [CW-1:0] x_min_nxt, x_max_nxt, y_min_nxt, y_max_nxt;

   assign sink_ready = source_ready || !source_valid;
   assign sink_xfer  = sink_valid && sink_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         source_valid <= 1'b0;
         source_data  <= '0;
         source_sop   <= 1'b0;
         source_eop   <= 1'b0;
      end else if (sink_xfer) begin
         source_valid <= 1'b1;
         source_data  <= sink_data;
         source_sop   <= sink_sop;
         source_eop   <= sink_eop;
      end else if (source_ready) begin
         source_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      if (sink_xfer) begin
         if (sink_sop) begin
            if (sink_eop)                    state_nxt = ST_IDLE;
            else if (sink_data[3:0] == 4'h0) state_nxt = ST_VIDEO;
            else                             state_nxt = ST_OTHER;
         end else if (sink_eop) begin
            state_nxt = ST_IDLE;
         end
      end
   end

   assign pixel_xfer = sink_xfer && !sink_sop && (state == ST_VIDEO);
   assign in_frame   = y_cnt < Y_END;
   assign hit        = pixel_xfer && in_frame &&
                       (sink_data[23:16] >= r_min) &&
                       (sink_data[15:8]  <= g_max) &&
                       (sink_data[7:0]   <= b_max);

   // Running box including the current pixel, so a hit on the eop beat is published too.
   always_comb begin
      acc_valid_nxt = acc_valid;
      x_min_nxt     = acc_x_min;
      x_max_nxt     = acc_x_max;
      y_min_nxt     = acc_y_min;
      y_max_nxt     = acc_y_max;
      if (hit) begin
         acc_valid_nxt = 1'b1;
         if (!acc_valid) begin
            x_min_nxt = x_cnt;
            x_max_nxt = x_cnt;
            y_min_nxt = y_cnt;
            y_max_nxt = y_cnt;
         end else begin
            if (x_cnt < acc_x_min) x_min_nxt = x_cnt;
            if (x_cnt > acc_x_max) x_max_nxt = x_cnt;
            if (y_cnt < acc_y_min) y_min_nxt = y_cnt;
            if (y_cnt > acc_y_max) y_max_nxt = y_cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_cnt       <= '0;
         y_cnt       <= '0;
         acc_valid   <= 1'b0;
         acc_x_min   <= '0;
         acc_x_max   <= '0;
         acc_y_min   <= '0;
         acc_y_max   <= '0;
         bbox_x_min  <= '0;
         bbox_x_max  <= '0;
         bbox_y_min  <= '0;
         bbox_y_max  <= '0;
         bbox_valid  <= 1'b0;
         bbox_strobe <= 1'b0;
      end else begin
         bbox_strobe <= 1'b0;
         if (sink_xfer && sink_sop) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            acc_valid <= 1'b0;
            acc_x_min <= '0;
            acc_x_max <= '0;
            acc_y_min <= '0;
            acc_y_max <= '0;
         end else if (pixel_xfer) begin
            acc_valid <= acc_valid_nxt;
            acc_x_min <= x_min_nxt;
            acc_x_max <= x_max_nxt;
            acc_y_min <= y_min_nxt;
            acc_y_max <= y_max_nxt;
            // Counters park at y == IMG_H; excess pixels are forwarded but not analysed.
            if (in_frame) begin
               if (x_cnt == X_LAST) begin
                  x_cnt <= '0;
                  y_cnt <= y_cnt + CW'(1);
               end else begin
                  x_cnt <= x_cnt + CW'(1);
               end
            end
            if (sink_eop) begin
               bbox_x_min  <= x_min_nxt;
               bbox_x_max  <= x_max_nxt;
               bbox_y_min  <= y_min_nxt;
               bbox_y_max  <= y_max_nxt;
               bbox_valid  <= acc_valid_nxt;
               bbox_strobe <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_colour_bbox_detect.sv
// Directed bench for colour_bbox_detect on an 8x4 image: passthrough, packet types,
// frame boundaries, backpressure and reset; boxes and beat streams are checked against hand values.
module tb_colour_bbox_detect;

   localparam int CW = 11;
   localparam logic [23:0] HIT   = 24'hFF2010;
   localparam logic [23:0] BLACK = 24'h000000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [23:0]   sink_data = '0;
   logic          sink_valid = 1'b0;
   logic          sink_ready;
   logic          sink_sop = 1'b0;
   logic          sink_eop = 1'b0;
   logic [23:0]   source_data;
   logic          source_valid;
   logic          source_ready = 1'b0;
   logic          source_sop;
   logic          source_eop;
   logic [7:0]    r_min = 8'h80;
   logic [7:0]    g_max = 8'h40;
   logic [7:0]    b_max = 8'h40;
   logic [CW-1:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
   logic          bbox_valid;
   logic          bbox_strobe;

   int   checks = 0;
   int   errors = 0;
   bit   rnd_ready = 1'b0;
   bit   ready_force = 1'b0;

   logic [25:0]       exp_q[$];
   logic [25:0]       out_q[$];
   logic [4*CW:0]     box_q[$];

   colour_bbox_detect #(.IMG_W(8), .IMG_H(4), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
      .sink_sop(sink_sop), .sink_eop(sink_eop),
      .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
      .source_sop(source_sop), .source_eop(source_eop),
      .r_min(r_min), .g_max(g_max), .b_max(b_max),
      .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
      .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
      .bbox_valid(bbox_valid), .bbox_strobe(bbox_strobe)
   );

   always #5 clk = ~clk;

   always @(negedge clk) source_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;

   // Observe handshakes and strobes just before each rising edge.
   always begin
      @(negedge clk);
      #3;
      if (source_valid && source_ready) out_q.push_back({source_sop, source_eop, source_data});
      if (bbox_strobe) box_q.push_back({bbox_valid, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max});
   end

   function automatic logic [4*CW:0] pack_box(input bit v, input int x0, x1, y0, y1);
      return {v, CW'(x0), CW'(x1), CW'(y0), CW'(y1)};
   endfunction

   function automatic int stream_diff();
      if (out_q.size() != exp_q.size()) return -2;
      for (int i = 0; i < exp_q.size(); i++)
         if (out_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop, input bit gaps);
      bit acc = 1'b0;
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
         sink_valid = 1'b0;
         repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      sink_data  = d;
      sink_sop   = sop;
      sink_eop   = eop;
      sink_valid = 1'b1;
      for (int n = 0; n < 500; n++) begin
         #1;
         acc = sink_ready;
         @(posedge clk);
         if (acc) break;
         @(negedge clk);
      end
      if (acc) begin
         exp_q.push_back({sop, eop, d});
      end else begin
         checks++;
         errors++;
         $display("FAIL sink_accept_timeout: beat %h never accepted", d);
      end
   endtask

   task automatic send_video(input logic [63:0] hits, input int npix, input bit with_eop, input bit gaps);
      send_beat(BLACK, 1'b1, 1'b0, gaps);
      for (int i = 0; i < npix; i++)
         send_beat(hits[i] ? HIT : BLACK, 1'b0, with_eop && (i == npix - 1), gaps);
   endtask

   task automatic drain();
      @(negedge clk);
      sink_valid  = 1'b0;
      sink_sop    = 1'b0;
      sink_eop    = 1'b0;
      rnd_ready   = 1'b0;
      ready_force = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL reset_source_valid: got %b expected 0", source_valid); end
      checks++; if (sink_ready !== 1'b1) begin errors++; $display("FAIL reset_sink_ready: got %b expected 1", sink_ready); end
      checks++; if (bbox_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", bbox_strobe); end
      checks++;
      if ({bbox_valid, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max} !== pack_box(0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL reset_bbox: got %h expected 0", {bbox_valid, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max});
      end
      checks++;
      if ({source_sop, source_eop, source_data} !== 26'h0) begin
         errors++; $display("FAIL reset_source_beat: got %h expected 0", {source_sop, source_eop, source_data});
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (sink_ready !== 1'b1) begin errors++; $display("FAIL after_reset_sink_ready: got %b expected 1", sink_ready); end
   endtask

   task automatic test_passthrough();
      int base = box_q.size();
      ready_force = 1'b0;
      send_beat(24'h123456, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      checks++; if (source_valid !== 1'b1) begin errors++; $display("FAIL pass_latency_valid: got %b expected 1", source_valid); end
      checks++;
      if ({source_sop, source_eop, source_data} !== {2'b10, 24'h123456}) begin
         errors++; $display("FAIL pass_data: got %h expected %h", {source_sop, source_eop, source_data}, {2'b10, 24'h123456});
      end
      checks++; if (sink_ready !== 1'b0) begin errors++; $display("FAIL pass_backpressure: got %b expected 0", sink_ready); end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (!(source_valid === 1'b1 && source_data === 24'h123456)) begin
         errors++; $display("FAIL pass_hold: got valid %b data %h expected 1 123456", source_valid, source_data);
      end
      ready_force = 1'b1;
      send_beat(24'hABCDEF, 1'b0, 1'b1, 1'b0);
      drain();
      checks++; if (stream_diff() !== -1) begin errors++; $display("FAIL pass_stream: diff at %0d expected -1", stream_diff()); end
      checks++; if (box_q.size() !== base) begin errors++; $display("FAIL pass_no_strobe: got %0d strobes expected 0", box_q.size() - base); end
   endtask

   task automatic test_single_frame();
      int base = box_q.size();
      send_video((64'd1 << 10) | (64'd1 << 29), 32, 1'b1, 1'b0);
      drain();
      checks++;
      if (box_q.size() !== base + 1) begin
         errors++; $display("FAIL frame_strobes: got %0d expected 1", box_q.size() - base);
      end else begin
         checks++;
         if (box_q[base] !== pack_box(1, 2, 5, 1, 3)) begin errors++; $display("FAIL frame_box: got %h expected %h", box_q[base], pack_box(1, 2, 5, 1, 3)); end
      end
      send_video(64'd0, 32, 1'b1, 1'b0);
      drain();
      checks++;
      if (box_q.size() !== base + 2) begin
         errors++; $display("FAIL black_strobes: got %0d expected 1", box_q.size() - base - 1);
      end else begin
         checks++;
         if (box_q[base+1] !== pack_box(0, 0, 0, 0, 0)) begin errors++; $display("FAIL black_box: got %h expected 0", box_q[base+1]); end
      end
      checks++; if (bbox_valid !== 1'b0) begin errors++; $display("FAIL black_valid_held: got %b expected 0", bbox_valid); end
   endtask

   task automatic test_control_packet();
      int base = box_q.size();
      int first = exp_q.size();
      send_beat(24'h00000F, 1'b1, 1'b0, 1'b0);
      send_beat(HIT, 1'b0, 1'b0, 1'b0);
      send_beat(HIT, 1'b0, 1'b1, 1'b0);
      send_video(64'd1 << 7, 32, 1'b1, 1'b0);
      drain();
      checks++;
      if (box_q.size() !== base + 1) begin
         errors++; $display("FAIL ctrl_strobes: got %0d expected 1", box_q.size() - base);
      end else begin
         checks++;
         if (box_q[base] !== pack_box(1, 7, 7, 0, 0)) begin errors++; $display("FAIL ctrl_box: got %h expected %h", box_q[base], pack_box(1, 7, 7, 0, 0)); end
      end
      checks++;
      if (out_q.size() < first + 3 || out_q[first] !== {2'b10, 24'h00000F} ||
          out_q[first+1] !== {2'b00, HIT} || out_q[first+2] !== {2'b01, HIT}) begin
         errors++; $display("FAIL ctrl_forward: control packet not forwarded intact");
      end
      checks++; if (stream_diff() !== -1) begin errors++; $display("FAIL ctrl_stream: diff at %0d expected -1", stream_diff()); end
   endtask

   task automatic test_frame_length();
      int base = box_q.size();
      // Short frame: threshold edges, hits at (3,0) and the eop pixel (1,1).
      send_beat(BLACK, 1'b1, 1'b0, 1'b0);
      send_beat(24'h7F4040, 1'b0, 1'b0, 1'b0);
      send_beat(24'hFF4140, 1'b0, 1'b0, 1'b0);
      send_beat(24'hFF4041, 1'b0, 1'b0, 1'b0);
      send_beat(24'h804040, 1'b0, 1'b0, 1'b0);
      for (int i = 4; i < 9; i++) send_beat(BLACK, 1'b0, 1'b0, 1'b0);
      send_beat(HIT, 1'b0, 1'b1, 1'b0);
      // Long frame: hit on the last real pixel, hits beyond IMG_H ignored.
      send_video((64'd1 << 31) | (64'd1 << 32) | (64'd1 << 35), 36, 1'b1, 1'b0);
      drain();
      checks++;
      if (box_q.size() !== base + 2) begin
         errors++; $display("FAIL length_strobes: got %0d expected 2", box_q.size() - base);
      end else begin
         checks++;
         if (box_q[base] !== pack_box(1, 1, 3, 0, 1)) begin errors++; $display("FAIL short_box: got %h expected %h", box_q[base], pack_box(1, 1, 3, 0, 1)); end
         checks++;
         if (box_q[base+1] !== pack_box(1, 7, 7, 3, 3)) begin errors++; $display("FAIL long_box: got %h expected %h", box_q[base+1], pack_box(1, 7, 7, 3, 3)); end
      end
   endtask

   task automatic test_back_to_back();
      int base = box_q.size();
      rnd_ready = 1'b1;
      send_video((64'd1 << 0) | (64'd1 << 31), 32, 1'b1, 1'b1);
      send_video((64'd1 << 13) | (64'd1 << 18), 32, 1'b1, 1'b1);
      send_video(64'd0, 32, 1'b1, 1'b1);
      drain();
      checks++;
      if (box_q.size() !== base + 3) begin
         errors++; $display("FAIL b2b_strobes: got %0d expected 3", box_q.size() - base);
      end else begin
         checks++;
         if (box_q[base] !== pack_box(1, 0, 7, 0, 3)) begin errors++; $display("FAIL b2b_box0: got %h expected %h", box_q[base], pack_box(1, 0, 7, 0, 3)); end
         checks++;
         if (box_q[base+1] !== pack_box(1, 2, 5, 1, 2)) begin errors++; $display("FAIL b2b_box1: got %h expected %h", box_q[base+1], pack_box(1, 2, 5, 1, 2)); end
         checks++;
         if (box_q[base+2] !== pack_box(0, 0, 0, 0, 0)) begin errors++; $display("FAIL b2b_box2: got %h expected 0", box_q[base+2]); end
      end
      checks++; if (stream_diff() !== -1) begin errors++; $display("FAIL b2b_stream: diff at %0d expected -1", stream_diff()); end
   endtask

   task automatic test_restart();
      int base = box_q.size();
      send_video(64'd1 << 9, 10, 1'b0, 1'b0);
      send_video(64'd1 << 0, 32, 1'b1, 1'b0);
      drain();
      checks++;
      if (box_q.size() !== base + 1) begin
         errors++; $display("FAIL restart_strobes: got %0d expected 1", box_q.size() - base);
      end else begin
         checks++;
         if (box_q[base] !== pack_box(1, 0, 0, 0, 0)) begin errors++; $display("FAIL restart_box: got %h expected %h", box_q[base], pack_box(1, 0, 0, 0, 0)); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int base = box_q.size();
      send_video((64'd1 << 3) | (64'd1 << 11), 12, 1'b0, 1'b0);
      @(negedge clk);
      sink_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (!(source_valid === 1'b0 && bbox_strobe === 1'b0 && sink_ready === 1'b1)) begin
         errors++; $display("FAIL midreset_outputs: got valid %b strobe %b ready %b expected 0 0 1", source_valid, bbox_strobe, sink_ready);
      end
      reset = 1'b0;
      // Orphan pixels without a sop must not start a frame.
      for (int i = 0; i < 3; i++) send_beat(HIT, 1'b0, i == 2, 1'b0);
      send_video(64'd1 << 20, 32, 1'b1, 1'b0);
      drain();
      checks++;
      if (box_q.size() !== base + 1) begin
         errors++; $display("FAIL midreset_strobes: got %0d expected 1", box_q.size() - base);
      end else begin
         checks++;
         if (box_q[base] !== pack_box(1, 4, 4, 2, 2)) begin errors++; $display("FAIL midreset_box: got %h expected %h", box_q[base], pack_box(1, 4, 4, 2, 2)); end
      end
      checks++; if (stream_diff() !== -1) begin errors++; $display("FAIL midreset_stream: diff at %0d expected -1", stream_diff()); end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_single_frame();
      test_control_packet();
      test_frame_length();
      test_back_to_back();
      test_restart();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
